// File: rtl/my_nios2_system_cpu_oci_dct_packer.sv
// Packs 2-bit direct-branch trace codes into 15-entry DCT frames and hands
// completed frames to the trace output path through a valid/ready slot.
module my_nios2_system_cpu_oci_dct_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_enable,
  input  logic        code_valid,
  input  logic [1:0]  code,
  input  logic        flush,
  input  logic        overflow_clr,
  input  logic        frame_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frame_valid,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic        overflow
);

  // state | meaning
  // EMPTY | no codes buffered
  // ACCUM | 1..14 codes buffered, accepting
  // HELD  | frame frozen (full or flush pending), waiting for a free slot
  typedef enum logic [1:0] {EMPTY, ACCUM, HELD} state_t;

  state_t      state, state_n;
  logic [29:0] buf_n, fd_n, nb;
  logic [3:0]  cnt_n, fc_n, nc;
  logic        fv_n, accept, sf, emit, drop;

  assign accept = code_valid & trace_enable;
  assign nb     = {dct_buffer[27:0], code};
  assign nc     = dct_count + 4'd1;
  assign sf     = ~frame_valid | frame_ready;

  always_comb begin
    state_n = state;
    buf_n   = dct_buffer;
    cnt_n   = dct_count;
    fv_n    = frame_valid & ~frame_ready;
    fd_n    = frame_data;
    fc_n    = frame_count;
    drop    = 1'b0;
    emit    = 1'b0;
    case (state)
      EMPTY, ACCUM: begin
        emit = (accept && nc == 4'd15) || (flush && (dct_count != 4'd0 || accept));
        if (emit) begin
          if (sf) begin
            fv_n    = 1'b1;
            fd_n    = accept ? nb : dct_buffer;
            fc_n    = accept ? nc : dct_count;
            buf_n   = '0;
            cnt_n   = '0;
            state_n = EMPTY;
          end else begin
            if (accept) begin
              buf_n = nb;
              cnt_n = nc;
            end
            state_n = HELD;
          end
        end else if (accept) begin
          buf_n   = nb;
          cnt_n   = nc;
          state_n = ACCUM;
        end
      end
      HELD: begin
        if (sf) begin
          fv_n = 1'b1;
          fd_n = dct_buffer;
          fc_n = dct_count;
          // a code arriving on the release cycle starts the next frame
          if (accept) begin
            buf_n   = {28'd0, code};
            cnt_n   = 4'd1;
            state_n = ACCUM;
          end else begin
            buf_n   = '0;
            cnt_n   = '0;
            state_n = EMPTY;
          end
        end else if (accept) begin
          drop = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      dct_buffer  <= '0;
      dct_count   <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      dct_buffer  <= buf_n;
      dct_count   <= cnt_n;
      frame_valid <= fv_n;
      frame_data  <= fd_n;
      frame_count <= fc_n;
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

endmodule
